output_drain: RTL
=================

OUTPUT_DRAIN -- requirements
Module: output_drain

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits.
REQ-002 Parameter DEPTH, default 8: buffer entries; power of two, 2..64.
REQ-003 clock  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 in_valid  input  1: datapath offers a result byte.
REQ-006 in_data  input  DATA_W: result byte from datapath.
REQ-007 in_last  input  1: byte is the final one of a result frame.
REQ-008 in_ready  output  1: block accepts a byte this cycle.
REQ-009 out_valid  output  1: head byte presented to the external consumer.
REQ-010 out_data  output  DATA_W: head byte.
REQ-011 out_last  output  1: head byte ends a frame.
REQ-012 out_ready  input  1: consumer takes the head byte this cycle.
REQ-013 level  output  log2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-014 frame_busy  output  1: a frame has been partly accepted but its last byte has not yet been accepted.
REQ-015 frames_sent  output  8: count of frames fully drained.

Function
REQ-016 Push occurs when in_valid and in_ready are both 1 at a clock edge; {in_data, in_last} is written at the tail.
REQ-017 Pop occurs when out_valid and out_ready are both 1 at a clock edge; the head advances.
REQ-018 in_ready is 1 when level < DEPTH and rst is 0; it is derived from registered state only, never from out_ready.
REQ-019 When full, a same-cycle pop does not enable a push; in_ready stays 0 for that cycle.
REQ-020 out_valid is 1 when level > 0; out_data and out_last show the head entry (first-word fall-through); they hold 0 when empty.
REQ-021 Latency: a byte pushed into an empty buffer at edge N is presented with out_valid=1 after edge N; there is no same-cycle bypass.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_last are held stable.
REQ-023 Simultaneous push and pop: level is unchanged, and both pointers advance.
REQ-024 Read and write pointers wrap modulo DEPTH.
REQ-025 Frame state machine with two states. IDLE moves to ACTIVE on a push with in_last=0. ACTIVE moves to IDLE on a push with in_last=1. A push with in_last=1 in IDLE (single-byte frame) stays in IDLE. frame_busy=1 only in ACTIVE.
REQ-026 frames_sent increments by 1 on each pop with out_last=1, and wraps from 255 to 0.
REQ-027 in_data is not interpreted; all DATA_W bits pass through unchanged.

Reset
REQ-028 While rst=1 at an edge: pointers are cleared, level=0, the state machine goes to IDLE, frames_sent=0, and buffer contents are discarded.
REQ-029 Outputs during and after reset until the first push: out_valid=0, out_data=0, out_last=0, frame_busy=0. in_ready=0 while rst=1 and 1 on the first cycle after release.
REQ-030 Reset asserted mid-frame or mid-drain discards all pending bytes and the partial frame; no byte is presented after release until a new push occurs.

Structure
REQ-031 The shared package holds DATA_W, the default DEPTH, a packed entry typedef {last, data}, and the frame-state enum {IDLE, ACTIVE}.
REQ-032 Storage is a sub-module output_drain_mem: DEPTH x (DATA_W+1), one write port, and an asynchronous read port at the head pointer. Control logic stays in output_drain.

Verification
REQ-033 Reset, then push 0x11, 0x22, 0x33 (last on 0x33) with out_ready=1 -> outputs 0x11, 0x22, 0x33 in order, each one cycle after its push, out_last only with 0x33, frames_sent=1.
REQ-034 out_ready=0, push 8 bytes 0x00..0x07 -> level=8, in_ready=0, and a 9th in_valid is not accepted; raise out_ready -> 0x00..0x07 drain in order.
REQ-035 Full buffer with push and pop asserted in the same cycle -> only the pop occurs, level=7, and in_ready=1 on the next cycle.
REQ-036 Stream 20 bytes continuously with out_ready=1 -> the pointers wrap, and there is no loss, duplication or reordering.
REQ-037 Assert rst after 2 bytes of a 4-byte frame (frame_busy=1) -> next cycle out_valid=0, level=0, frame_busy=0, frames_sent=0.
REQ-038 Drain 256 single-byte frames (in_last=1 on every byte) -> frames_sent wraps to 0, and frame_busy stays 0 throughout.

Source files
------------

// File: rtl/output_drain_pkg.sv
// Output drain shared types.
// Payload width, default depth, entry layout and frame state.
package output_drain_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_t;

endpackage

// File: rtl/output_drain_if.sv
// Output drain handshake bundle.
// Master drives producer/consumer side, slave is the drain.
interface output_drain_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic [LW-1:0]     level;
  logic              frame_busy;
  logic [7:0]        frames_sent;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last,
    input  level, frame_busy, frames_sent
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last,
    output level, frame_busy, frames_sent
  );

endinterface

// File: rtl/output_drain_mem.sv
// Output drain storage array.
// One write port, asynchronous read at the head pointer.
module output_drain_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clock,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W:0]            rdata
);

  logic [DATA_W:0] mem [DEPTH];

  // Store the tail entry on a push.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/output_drain.sv
// Output drain: framed result buffer toward an external consumer.
// FIFO control, frame tracking and drained-frame counter.
module output_drain #(
  parameter int DATA_W = output_drain_pkg::DATA_W,
  parameter int DEPTH  = output_drain_pkg::DEPTH
) (
  input  logic                 clock,
  input  logic                 rst,
  output_drain_if.slave        bus
);

  import output_drain_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_q;
  logic [7:0]      frames_q;
  logic [DATA_W:0] rd_word;
  logic            push;
  logic            pop;
  frame_state_t    state_q;
  frame_state_t    state_d;

  assign bus.in_ready  = !rst && (level_q != FULL);
  assign bus.out_valid = (level_q != '0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign bus.out_data = bus.out_valid
                      ? rd_word[DATA_W-1:0] : '0;
  assign bus.out_last = bus.out_valid && rd_word[DATA_W];
  assign bus.level       = level_q;
  assign bus.frames_sent = frames_q;

  output_drain_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({bus.in_last, bus.in_data}),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // Pointers, occupancy and drained-frame count.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      frames_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (pop && bus.out_last) frames_q <= frames_q + 8'd1;
    end
  end

  // Frame state register.
  always_ff @(posedge clock) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame opens on a non-last push, closes on a last push.
  always_comb begin
    state_d = state_q;
    if (push) begin
      unique case (1'b1)
        (state_q == IDLE):   if (!bus.in_last) state_d = ACTIVE;
        (state_q == ACTIVE): if (bus.in_last)  state_d = IDLE;
        default:             state_d = state_q;
      endcase
    end
  end

  // Busy while a frame is partially accepted.
  always_comb begin
    bus.frame_busy = (state_q == ACTIVE);
  end

endmodule
